// File: rtl/frame_diff_accumulator.sv
// -----------------------------------------------------------------------------
// frame_diff_accumulator
//
// Purpose:
//   Sits after the 8-bit adder/subtractor and keeps a saturating signed
//   running sum of its results over a frame of FRAME_LEN samples. When a frame
//   completes, or when flush ends a non-empty frame early, the sum, the sample
//   count and a sticky overflow flag are presented on a registered
//   valid/ready output port. The block accepts no new samples until that
//   result has been taken.
//
// Parameters:
//   FRAME_LEN  samples per frame (1..255)
//   ACC_W      accumulator / out_sum width in bits (9..32)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset, beats every other event
//   in_data    signed 8-bit sample
//   in_valid   in_data valid this cycle
//   in_ready   block can take a sample (state decode, forced low in reset)
//   flush      close the current frame early (ignored when no frame is open)
//   out_valid  out_sum / out_count / out_ovf hold a finished frame
//   out_ready  consumer takes the finished frame this cycle
//   out_sum    saturated signed frame sum
//   out_count  number of samples in the frame
//   out_ovf    saturation happened at least once in the frame
// -----------------------------------------------------------------------------
module frame_diff_accumulator #(
    parameter int FRAME_LEN = 16,
    parameter int ACC_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_ovf
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [7:0] FRAME_LEN_C = 8'(FRAME_LEN);

    // Saturation limits of an ACC_W-bit two's-complement value.
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       state_reg,     state_next;
    logic [ACC_W-1:0] acc_reg,       acc_next;
    logic [7:0]       cnt_reg,       cnt_next;
    logic             ovf_reg,       ovf_next;
    logic             out_valid_reg, out_valid_next;
    logic [ACC_W-1:0] out_sum_reg,   out_sum_next;
    logic [7:0]       out_count_reg, out_count_next;
    logic             out_ovf_reg,   out_ovf_next;

    // -------------------------------------------------------------------------
    // Saturating adder
    //
    // The sum is formed one bit wider than the accumulator. Since both
    // operands fit in ACC_W bits, the wide result is exact, and it left the
    // ACC_W range exactly when its top two bits disagree; the top bit then
    // tells which rail to clamp to.
    // -------------------------------------------------------------------------
    logic [ACC_W:0]   sample_ext;
    logic [ACC_W:0]   acc_ext;
    logic [ACC_W:0]   sum_wide;
    logic             sat_hi;
    logic             sat_lo;
    logic             sat_any;
    logic [ACC_W-1:0] acc_sat;

    assign sample_ext[7:0] = in_data;

    genvar gi;
    generate
        for (gi = 8; gi <= ACC_W; gi++) begin : g_sample_sext
            assign sample_ext[gi] = in_data[7];
        end
    endgenerate

    assign acc_ext  = {acc_reg[ACC_W-1], acc_reg};
    assign sum_wide = acc_ext + sample_ext;
    assign sat_hi   = ~sum_wide[ACC_W] &  sum_wide[ACC_W-1];
    assign sat_lo   =  sum_wide[ACC_W] & ~sum_wide[ACC_W-1];
    assign sat_any  = sat_hi | sat_lo;

    always_comb begin
        acc_sat = sum_wide[ACC_W-1:0];
        if (sat_hi) begin
            acc_sat = ACC_MAX;
        end else if (sat_lo) begin
            acc_sat = ACC_MIN;
        end
    end

    // -------------------------------------------------------------------------
    // Handshake decode
    //
    // in_ready depends on state only (plus reset), so there is no
    // combinational path from in_valid or out_ready to any output.
    // -------------------------------------------------------------------------
    logic accept_open;
    logic take;
    logic frame_done;
    logic [7:0] cnt_inc;

    assign accept_open = (state_reg != ST_HOLD);
    assign in_ready    = accept_open & ~rst;
    assign take        = in_valid & accept_open;
    assign cnt_inc     = cnt_reg + 8'd1;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        ovf_next       = ovf_reg;
        out_valid_next = out_valid_reg;
        out_sum_next   = out_sum_reg;
        out_count_next = out_count_reg;
        out_ovf_next   = out_ovf_reg;
        frame_done     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // acc is zero here, so acc_sat is simply the extended sample.
                // flush is ignored: an empty frame is never emitted, and a
                // flush arriving with the first sample does not close it.
                if (take) begin
                    acc_next   = acc_sat;
                    cnt_next   = 8'd1;
                    ovf_next   = sat_any;
                    state_next = ST_ACCUM;
                    frame_done = (FRAME_LEN_C == 8'd1);
                end
            end

            ST_ACCUM: begin
                if (take) begin
                    acc_next = acc_sat;
                    cnt_next = cnt_inc;
                    ovf_next = ovf_reg | sat_any;
                end
                // A sample arriving together with flush is counted first.
                frame_done = (take && (cnt_inc == FRAME_LEN_C)) || flush;
            end

            ST_HOLD: begin
                if (out_ready) begin
                    state_next     = ST_IDLE;
                    out_valid_next = 1'b0;
                    acc_next       = '0;
                    cnt_next       = 8'd0;
                    ovf_next       = 1'b0;
                end
            end

            default: begin
                state_next     = ST_IDLE;
                acc_next       = '0;
                cnt_next       = 8'd0;
                ovf_next       = 1'b0;
                out_valid_next = 1'b0;
            end
        endcase

        // Closing a frame captures the post-update accumulator values.
        if (frame_done) begin
            state_next     = ST_HOLD;
            out_valid_next = 1'b1;
            out_sum_next   = acc_next;
            out_count_next = cnt_next;
            out_ovf_next   = ovf_next;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            acc_reg       <= '0;
            cnt_reg       <= 8'd0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_sum_reg   <= '0;
            out_count_reg <= 8'd0;
            out_ovf_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            ovf_reg       <= ovf_next;
            out_valid_reg <= out_valid_next;
            out_sum_reg   <= out_sum_next;
            out_count_reg <= out_count_next;
            out_ovf_reg   <= out_ovf_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign out_count = out_count_reg;
    assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_frame_diff_accumulator.sv
// -----------------------------------------------------------------------------
// tb_frame_diff_accumulator
//
// Two instances share all inputs: dut_a at ACC_W=16 and dut_b at ACC_W=10,
// both with FRAME_LEN=16. A reference model steps at each rising edge and
// pushes the expected frame result into a per-instance queue; a negedge
// monitor compares the presented result every cycle that out_valid is high
// and checks in_ready/out_valid against the model. Scenario tasks add
// explicit checks against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_frame_diff_accumulator;

    localparam int FL = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        flush;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_ovf_a;
    logic [15:0] out_sum_a;
    logic [7:0]  out_count_a;
    logic        in_ready_b, out_valid_b, out_ovf_b;
    logic [9:0]  out_sum_b;
    logic [7:0]  out_count_b;

    frame_diff_accumulator #(.FRAME_LEN(FL), .ACC_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a), .flush(flush), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_sum(out_sum_a), .out_count(out_count_a),
        .out_ovf(out_ovf_a)
    );

    frame_diff_accumulator #(.FRAME_LEN(FL), .ACC_W(10)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .flush(flush), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_sum(out_sum_b), .out_count(out_count_b),
        .out_ovf(out_ovf_b)
    );

    typedef struct {
        longint sum;
        int     cnt;
        bit     ovf;
    } res_t;

    res_t   q_a[$];
    res_t   q_b[$];
    int     vectors     = 0;
    int     miscompares = 0;
    int     emits       = 0;
    bit     mon_en      = 1'b0;

    bit     m_hold  = 1'b0;
    longint m_acc_a = 0;
    longint m_acc_b = 0;
    int     m_cnt   = 0;
    bit     m_ovf_a = 1'b0;
    bit     m_ovf_b = 1'b0;

    function automatic longint clamp(longint v, int w);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -(longint'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic bit over(longint v, int w);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -(longint'(1) <<< (w - 1));
        return (v > hi) || (v < lo);
    endfunction

    // Reference model: called once per rising edge with the inputs that the
    // DUT samples at that edge.
    task automatic model_step();
        longint na, nb;
        bit     was_open;
        res_t   ra, rb;
        if (rst) begin
            m_hold = 0; m_acc_a = 0; m_acc_b = 0; m_cnt = 0;
            m_ovf_a = 0; m_ovf_b = 0;
            q_a.delete(); q_b.delete();
            return;
        end
        if (m_hold) begin
            if (out_ready) begin
                m_hold = 0;
                ra = q_a.pop_front();
                rb = q_b.pop_front();
            end
            return;
        end
        was_open = (m_cnt != 0);
        if (in_valid) begin
            na = m_acc_a + longint'($signed(in_data));
            nb = m_acc_b + longint'($signed(in_data));
            m_ovf_a = m_ovf_a | over(na, 16);
            m_ovf_b = m_ovf_b | over(nb, 10);
            m_acc_a = clamp(na, 16);
            m_acc_b = clamp(nb, 10);
            m_cnt   = m_cnt + 1;
        end
        if ((in_valid && m_cnt == FL) || (flush && was_open)) begin
            ra.sum = m_acc_a; ra.cnt = m_cnt; ra.ovf = m_ovf_a;
            rb.sum = m_acc_b; rb.cnt = m_cnt; rb.ovf = m_ovf_b;
            q_a.push_back(ra);
            q_b.push_back(rb);
            m_hold = 1;
            m_acc_a = 0; m_acc_b = 0; m_cnt = 0; m_ovf_a = 0; m_ovf_b = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit f);
        in_valid = v;
        in_data  = d;
        flush    = f;
        tick();
    endtask

    // Monitor: handshake decode and scoreboard comparison each cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            longint   sa, sb;
            logic [15:0] ea;
            logic [9:0]  eb;
            vectors++;
            if (in_ready_a !== (!m_hold && !rst) || in_ready_b !== (!m_hold && !rst)) begin
                miscompares++;
                $display("FAIL in_ready got a=%b b=%b want %b", in_ready_a, in_ready_b, !m_hold && !rst);
            end
            vectors++;
            if (out_valid_a !== m_hold || out_valid_b !== m_hold) begin
                miscompares++;
                $display("FAIL out_valid got a=%b b=%b want %b", out_valid_a, out_valid_b, m_hold);
            end
            if (m_hold && q_a.size() > 0 && q_b.size() > 0) begin
                sa = q_a[0].sum; sb = q_b[0].sum;
                ea = sa[15:0];   eb = sb[9:0];
                vectors++;
                if (out_sum_a !== ea || out_count_a !== 8'(q_a[0].cnt) || out_ovf_a !== q_a[0].ovf) begin
                    miscompares++;
                    $display("FAIL sb_a got sum=%h cnt=%0d ovf=%b want sum=%h cnt=%0d ovf=%b",
                             out_sum_a, out_count_a, out_ovf_a, ea, q_a[0].cnt, q_a[0].ovf);
                end
                vectors++;
                if (out_sum_b !== eb || out_count_b !== 8'(q_b[0].cnt) || out_ovf_b !== q_b[0].ovf) begin
                    miscompares++;
                    $display("FAIL sb_b got sum=%h cnt=%0d ovf=%b want sum=%h cnt=%0d ovf=%b",
                             out_sum_b, out_count_b, out_ovf_b, eb, q_b[0].cnt, q_b[0].ovf);
                end
                $display("frame: a sum=%h cnt=%0d ovf=%b | b sum=%h ovf=%b ready=%b",
                         out_sum_a, out_count_a, out_ovf_a, out_sum_b, out_ovf_b, out_ready);
            end
            if (out_valid_a && out_ready) emits++;
        end
    end

    task automatic test_reset();
        rst = 1; in_valid = 0; in_data = 0; flush = 0; out_ready = 1;
        tick();
        tick();
        mon_en = 1;
        vectors++;
        if (in_ready_a !== 1'b0 || out_valid_a !== 1'b0 || out_sum_a !== 16'h0 ||
            out_count_a !== 8'h0 || out_ovf_a !== 1'b0 || out_sum_b !== 10'h0) begin
            miscompares++;
            $display("FAIL reset_state got rdy=%b vld=%b sum=%h cnt=%h ovf=%b want 0 0 0 0 0",
                     in_ready_a, out_valid_a, out_sum_a, out_count_a, out_ovf_a);
        end
        rst = 0;
        #1;
        vectors++;
        if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready got %b %b want 1", in_ready_a, in_ready_b);
        end
    endtask

    task automatic test_ones();
        out_ready = 1;
        for (int i = 0; i < FL; i++) drive(1, 8'h01, 0);
        vectors++;
        if (out_valid_a !== 1 || out_sum_a !== 16'd16 || out_count_a !== 8'd16 || out_ovf_a !== 0) begin
            miscompares++;
            $display("FAIL ones got vld=%b sum=%h cnt=%0d ovf=%b want 1 0010 16 0",
                     out_valid_a, out_sum_a, out_count_a, out_ovf_a);
        end
        drive(0, 8'h00, 0);
        vectors++;
        if (out_valid_a !== 0) begin
            miscompares++;
            $display("FAIL ones_one_cycle got vld=%b want 0", out_valid_a);
        end
    endtask

    task automatic test_negative();
        for (int i = 0; i < FL; i++) drive(1, 8'hFF, 0);
        vectors++;
        if (out_sum_a !== 16'hFFF0 || out_sum_b !== 10'h3F0 || out_ovf_a !== 0 || out_ovf_b !== 0) begin
            miscompares++;
            $display("FAIL minus_one got a=%h b=%h ovf=%b%b want FFF0 3F0 00",
                     out_sum_a, out_sum_b, out_ovf_a, out_ovf_b);
        end
        drive(0, 8'h00, 0);
        for (int i = 0; i < FL; i++) drive(1, 8'h80, 0);
        vectors++;
        if (out_sum_a !== 16'hF800 || out_ovf_a !== 0 || out_sum_b !== 10'h200 || out_ovf_b !== 1) begin
            miscompares++;
            $display("FAIL min_sample got a=%h ovf=%b b=%h ovf=%b want F800 0 200 1",
                     out_sum_a, out_ovf_a, out_sum_b, out_ovf_b);
        end
        drive(0, 8'h00, 0);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < FL; i++) drive(1, 8'h7F, 0);
        vectors++;
        if (out_sum_b !== 10'h1FF || out_ovf_b !== 1 || out_sum_a !== 16'h07F0 || out_ovf_a !== 0) begin
            miscompares++;
            $display("FAIL sat_hi got b=%h ovf=%b a=%h ovf=%b want 1FF 1 07F0 0",
                     out_sum_b, out_ovf_b, out_sum_a, out_ovf_a);
        end
        drive(0, 8'h00, 0);
        for (int i = 0; i < FL; i++) drive(1, 8'h01, 0);
        vectors++;
        if (out_sum_b !== 10'd16 || out_ovf_b !== 0) begin
            miscompares++;
            $display("FAIL ovf_clears got b=%h ovf=%b want 010 0", out_sum_b, out_ovf_b);
        end
        drive(0, 8'h00, 0);
    endtask

    task automatic test_flush();
        int e0;
        for (int i = 0; i < 5; i++) drive(1, 8'h03, 0);
        drive(1, 8'h02, 1);
        vectors++;
        if (out_valid_a !== 1 || out_sum_a !== 16'd17 || out_count_a !== 8'd6 || out_sum_b !== 10'd17) begin
            miscompares++;
            $display("FAIL flush got vld=%b sum=%h cnt=%0d want 1 0011 6",
                     out_valid_a, out_sum_a, out_count_a);
        end
        drive(0, 8'h00, 0);
        e0 = emits;
        for (int i = 0; i < 3; i++) drive(0, 8'h00, 1);
        drive(0, 8'h00, 0);
        vectors++;
        if (emits !== e0 || out_valid_a !== 0) begin
            miscompares++;
            $display("FAIL flush_idle got emits=%0d vld=%b want %0d 0", emits, out_valid_a, e0);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        for (int i = 0; i < FL; i++) drive(1, 8'h02, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 8'h55, 0);
            vectors++;
            if (in_ready_a !== 0 || out_valid_a !== 1 || out_sum_a !== 16'd32 || out_count_a !== 8'd16) begin
                miscompares++;
                $display("FAIL hold_stable got rdy=%b vld=%b sum=%h cnt=%0d want 0 1 0020 16",
                         in_ready_a, out_valid_a, out_sum_a, out_count_a);
            end
        end
        out_ready = 1;
        drive(0, 8'h00, 0);
        vectors++;
        if (out_valid_a !== 0 || in_ready_a !== 1 || out_sum_a !== 16'd32) begin
            miscompares++;
            $display("FAIL release got vld=%b rdy=%b sum=%h want 0 1 0020",
                     out_valid_a, in_ready_a, out_sum_a);
        end
    endtask

    task automatic test_mid_reset();
        int e0;
        e0 = emits;
        for (int i = 0; i < 7; i++) drive(1, 8'h01, 0);
        rst = 1;
        drive(0, 8'h00, 0);
        vectors++;
        if (out_valid_a !== 0 || out_sum_a !== 0 || out_count_a !== 0 || out_ovf_a !== 0 ||
            in_ready_a !== 0 || emits !== e0) begin
            miscompares++;
            $display("FAIL mid_reset got vld=%b sum=%h cnt=%0d rdy=%b emits=%0d want 0 0 0 0 %0d",
                     out_valid_a, out_sum_a, out_count_a, in_ready_a, emits, e0);
        end
        rst = 0;
        for (int i = 0; i < FL; i++) drive(1, 8'h01, 0);
        vectors++;
        if (out_valid_a !== 1 || out_sum_a !== 16'd16 || out_count_a !== 8'd16) begin
            miscompares++;
            $display("FAIL after_reset got vld=%b sum=%h cnt=%0d want 1 0010 16",
                     out_valid_a, out_sum_a, out_count_a);
        end
        drive(0, 8'h00, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0);
        end
        out_ready = 1;
        for (int i = 0; i < 3; i++) drive(0, 8'h00, 0);
        vectors++;
        if (q_a.size() != 0 || out_valid_a !== 0) begin
            miscompares++;
            $display("FAIL drain got pending=%0d vld=%b want 0 0", q_a.size(), out_valid_a);
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_negative();
        test_saturate();
        test_flush();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
